mul_div_seq: RTL
================

// Module: mul_div_seq
// PURPOSE
//  Sequential RV M-extension unit: MUL/MULH/MULHU/MULHSU plus DIV/DIVU/REM/REMU.
//  Parametrised successor to the single-cycle combinational multiplier: iterative
//  shift-add / restoring-divide datapath, XLEN-wide, UNROLL bits per cycle.
//  Sits beside the ALU in execute; the core stalls on in_ready/out_valid.
// PARAMETERS
//  XLEN    32  operand/result width; even, >= 8
//  UNROLL  1   bits retired per iteration; power of 2, divides XLEN
// PORTS
//  clk        in   1     core clock, all state on rising edge
//  reset      in   1     synchronous, active-high
//  in_valid   in   1     operands/op presented
//  in_ready   out  1     unit idle, can accept
//  a          in   XLEN  rs1
//  b          in   XLEN  rs2
//  op         in   mul_div_op_t  one of the 8 M ops
//  abort      in   1     discard in-flight op (trap/flush)
//  out_valid  out  1     res valid, held until out_ready
//  out_ready  in   1     consumer takes res
//  res        out  XLEN  result
// BEHAVIOUR
//  - One clock; reset synchronous active-high. Reset: state=IDLE, in_ready=1,
//    out_valid=0, res=0, counter=0. Reset mid-operation drops the op, no output.
//  - FSM IDLE -> CALC -> DONE -> IDLE. in_ready = (state==IDLE) && !abort.
//  - Accept on in_valid && in_ready: latch op, |a|,|b| per signedness, result sign.
//    Signed: MULH a,b; MULHSU a only; DIV/REM a,b. Unsigned: rest.
//  - CALC: N = XLEN/UNROLL iterations, one per cycle; counter 0..N-1, then DONE.
//    Latency accept-edge to out_valid=1: N+1 cycles (N=32 -> 33; UNROLL=4 -> 9).
//  - Mul: 2*XLEN unsigned product; negate full 2*XLEN when sign set;
//    MUL -> low XLEN, MULH* -> high XLEN.
//  - Div: restoring, unsigned magnitudes; quotient negated if signs differ,
//    remainder takes sign of dividend.
//  - Fast path (IDLE -> DONE directly, latency 1):
//    b==0: DIV/DIVU res=all-ones; REM/REMU res=a.
//    signed overflow a=MIN,b=-1: DIV res=MIN; REM res=0.
//  - DONE: out_valid=1, res stable until out_ready; out_valid&&out_ready -> IDLE.
//    No accept in DONE (one bubble between back-to-back ops).
//  - abort: any state -> IDLE next edge, out_valid=0 next cycle; abort has
//    priority over simultaneous in_valid (no accept) and over out_ready.
//  - Inputs a/b/op ignored outside accept cycle; changing them mid-op has no effect.
// STRUCTURE
//  - decoder_pkg: mul_div_op_t (MD_MUL..MD_REMU), is_div/is_signed helpers.
//  - Local typedef for FSM state enum.
//  - Sub-module mul_div_step: combinational UNROLL-bit step (shift-add for mul,
//    compare-subtract for div), instantiated once; parent owns regs and FSM.
// TESTING
//  - MUL a=7,b=-3 (0xFFFFFFFD) -> res=0xFFFFFFEB, out_valid at cycle 33.
//  - MULH 0x80000000*0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF^2 -> 0xFFFFFFFE;
//    MULHSU a=-1,b=0xFFFFFFFF -> 0xFFFFFFFF.
//  - DIV -7/2 -> 0xFFFFFFFD, REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14, REMU -> 2.
//  - DIV 5/0 -> 0xFFFFFFFF, REMU 5/0 -> 5, DIV 0x80000000/-1 -> 0x80000000,
//    REM same -> 0; all with latency 1.
//  - Backpressure: out_ready=0 for 10 cycles -> res/out_valid held, in_ready=0;
//    abort at iteration 5 -> IDLE next cycle, no out_valid; reset mid-CALC same.
//  - UNROLL=4: random 10k ops vs reference model, latency 9; in_valid with
//    abort same cycle -> not accepted.

Source files
------------

// File: rtl/decoder_pkg.sv
// Operation encoding and classification helpers for the M-extension mul/div unit.
// Encoding follows the RV funct3 order so the decoder can pass funct3 straight through.
package decoder_pkg;

    typedef enum logic [2:0] {
        MD_MUL    = 3'd0,
        MD_MULH   = 3'd1,
        MD_MULHSU = 3'd2,
        MD_MULHU  = 3'd3,
        MD_DIV    = 3'd4,
        MD_DIVU   = 3'd5,
        MD_REM    = 3'd6,
        MD_REMU   = 3'd7
    } mul_div_op_t;

    function automatic logic is_div(input mul_div_op_t op);
        return op inside {MD_DIV, MD_DIVU, MD_REM, MD_REMU};
    endfunction

    function automatic logic is_rem(input mul_div_op_t op);
        return op inside {MD_REM, MD_REMU};
    endfunction

    function automatic logic is_signed_a(input mul_div_op_t op);
        return op inside {MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
    endfunction

    function automatic logic is_signed_b(input mul_div_op_t op);
        return op inside {MD_MULH, MD_DIV, MD_REM};
    endfunction

endpackage

// File: rtl/mul_div_step.sv
// Combinational UNROLL-bit iteration: shift-add multiply or restoring-divide step.
// acc holds {partial product, multiplier} for mul and {remainder, dividend/quotient} for div.
module mul_div_step #(
    parameter int XLEN   = 32,
    parameter int UNROLL = 1
) (
    input  logic [2*XLEN-1:0] acc_i,
    input  logic [XLEN-1:0]   opnd_i,
    input  logic              is_div_i,
    output logic [2*XLEN-1:0] acc_o
);

    logic [2*XLEN-1:0] chain [UNROLL+1];

    assign chain[0] = acc_i;

    for (genvar gi = 0; gi < UNROLL; gi++) begin : g_bit
        logic [2*XLEN-1:0] cur;
        logic [XLEN:0]     rem_sh;
        logic [XLEN:0]     diff;
        logic [XLEN:0]     sum;

        assign cur    = chain[gi];
        assign rem_sh = {cur[2*XLEN-1:XLEN], cur[XLEN-1]};
        assign diff   = rem_sh - {1'b0, opnd_i};
        assign sum    = {1'b0, cur[2*XLEN-1:XLEN]} + (cur[0] ? {1'b0, opnd_i} : '0);

        // A borrow out of diff means the divisor did not fit: keep the shifted remainder.
        assign chain[gi+1] = is_div_i
            ? (diff[XLEN] ? {rem_sh[XLEN-1:0], cur[XLEN-2:0], 1'b0}
                          : {diff[XLEN-1:0],   cur[XLEN-2:0], 1'b1})
            : {sum, cur[XLEN-1:1]};
    end

    assign acc_o = chain[UNROLL];

endmodule

// File: rtl/mul_div_seq.sv
// Iterative RV M-extension unit: unsigned-magnitude core with sign fix-up on the result,
// UNROLL bits per cycle, plus a one-cycle path for divide-by-zero and signed overflow.
module mul_div_seq
    import decoder_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int UNROLL = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  mul_div_op_t     op,
    input  logic            abort,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] res
);

    localparam int N     = XLEN / UNROLL;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [2*XLEN-1:0] acc_q, acc_step, prod;
    logic [XLEN-1:0]   opnd_q, res_q;
    mul_div_op_t       op_q;
    logic              neg_q, a_neg_q;

    logic              accept, last, a_neg, b_neg, div_zero, div_ovf, fast;
    logic [XLEN-1:0]   a_mag, b_mag, fast_res, calc_res, quo, rem;

    assign accept   = in_valid && in_ready;
    assign last     = (cnt_q == CNT_W'(N - 1));
    assign a_neg    = is_signed_a(op) && a[XLEN-1];
    assign b_neg    = is_signed_b(op) && b[XLEN-1];
    assign a_mag    = a_neg ? -a : a;
    assign b_mag    = b_neg ? -b : b;
    assign div_zero = is_div(op) && (b == '0);
    assign div_ovf  = is_div(op) && is_signed_b(op) && (a == MIN_VAL) && (b == '1);
    assign fast     = div_zero || div_ovf;

    always_comb begin
        fast_res = '0;
        if (div_zero) begin
            fast_res = is_rem(op) ? a : '1;
        end else if (!is_rem(op)) begin
            fast_res = MIN_VAL;
        end
    end

    mul_div_step #(
        .XLEN   (XLEN),
        .UNROLL (UNROLL)
    ) u_step (
        .acc_i    (acc_q),
        .opnd_i   (opnd_q),
        .is_div_i (is_div(op_q)),
        .acc_o    (acc_step)
    );

    // Quotient/product follow sign(a)^sign(b); remainder follows the dividend.
    assign prod = neg_q ? -acc_step : acc_step;
    assign quo  = neg_q ? -acc_step[XLEN-1:0] : acc_step[XLEN-1:0];
    assign rem  = a_neg_q ? -acc_step[2*XLEN-1:XLEN] : acc_step[2*XLEN-1:XLEN];

    always_comb begin
        case (op_q)
            MD_MUL:                       calc_res = prod[XLEN-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU: calc_res = prod[2*XLEN-1:XLEN];
            MD_DIV, MD_DIVU:              calc_res = quo;
            default:                      calc_res = rem;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = fast ? S_DONE : S_CALC;
            S_CALC:  if (last) state_d = S_DONE;
            S_DONE:  if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (abort) begin
            state_d = S_IDLE;
        end
    end

    always_comb begin
        in_ready  = (state_q == S_IDLE) && !abort;
        out_valid = (state_q == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            acc_q   <= '0;
            opnd_q  <= '0;
            op_q    <= MD_MUL;
            neg_q   <= 1'b0;
            a_neg_q <= 1'b0;
            res_q   <= '0;
        end else if (accept) begin
            cnt_q   <= '0;
            acc_q   <= {{XLEN{1'b0}}, a_mag};
            opnd_q  <= b_mag;
            op_q    <= op;
            neg_q   <= a_neg ^ b_neg;
            a_neg_q <= a_neg;
            if (fast) begin
                res_q <= fast_res;
            end
        end else if (state_q == S_CALC) begin
            acc_q <= acc_step;
            cnt_q <= last ? '0 : cnt_q + CNT_W'(1);
            if (last) begin
                res_q <= calc_res;
            end
        end
    end

    assign res = res_q;

endmodule
